// File: rtl/symbol_stream_xcheck.sv
// symbol_stream_xcheck: compares a DUT symbol stream against a reference
// stream. It searches for the integer symbol skew between them, then tracks
// symbol and mismatch counts per channel while locked.
//
// state  | meaning
// IDLE   | waiting for start, data ignored
// SEARCH | trying skews 0..MAX_SKEW-1, need LOCK_COUNT consecutive matches
// LOCKED | comparing at skew_found, counting symbols and errors
// FAIL   | no skew produced lock, outputs held until start or reset

module symbol_stream_xcheck #(
    parameter int WIDTH      = 18,
    parameter int NUM_CH     = 2,
    parameter int MAX_SKEW   = 8,
    parameter int SKEW_W     = 3,
    parameter int LOCK_COUNT = 16,
    parameter int LOSS_COUNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sym_clk_en,
    input  logic                      start,
    input  logic [NUM_CH*WIDTH-1:0]   ref_data,
    input  logic [NUM_CH*WIDTH-1:0]   dut_data,
    output logic [1:0]                state,
    output logic                      locked,
    output logic                      fail,
    output logic [SKEW_W-1:0]         skew_found,
    output logic [CNT_W-1:0]          sym_count,
    output logic [CNT_W-1:0]          err_count,
    output logic [NUM_CH-1:0]         ch_err_mask
);

    localparam int DW     = NUM_CH * WIDTH;
    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int LOSS_W = $clog2(LOSS_COUNT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_LOCKED = 2'd2,
        S_FAIL   = 2'd3
    } state_t;

    state_t              state_q, state_n;
    logic [SKEW_W-1:0]   trial_q, trial_n;
    logic [RUN_W-1:0]    run_q, run_n;
    logic [LOSS_W-1:0]   loss_q, loss_n, loss_inc;
    logic [SKEW_W-1:0]   skew_q, skew_n;
    logic [CNT_W-1:0]    sym_q, sym_n;
    logic [CNT_W-1:0]    err_q, err_n;
    logic [NUM_CH-1:0]   mask_q, mask_n;
    logic                locked_q, locked_n;
    logic                fail_q, fail_n;

    logic [DW-1:0]       dline [MAX_SKEW-1];
    logic [SKEW_W-1:0]   sel;
    logic [DW-1:0]       sel_data;
    logic [NUM_CH-1:0]   ch_mis;
    logic                full_match;

    // Reference delay line; shifts on every symbol enable regardless of state
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < MAX_SKEW - 1; k++) begin
                dline[k] <= '0;
            end
        end else if (sym_clk_en) begin
            dline[0] <= ref_data;
            for (int k = 1; k < MAX_SKEW - 1; k++) begin
                dline[k] <= dline[k-1];
            end
        end
    end

    // Pick the reference tap for the active skew and compare each channel
    always_comb begin
        sel      = (state_q == S_LOCKED) ? skew_q : trial_q;
        sel_data = ref_data;
        for (int k = 1; k < MAX_SKEW; k++) begin
            if (sel == SKEW_W'(k)) begin
                sel_data = dline[k-1];
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            ch_mis[c] = (dut_data[c*WIDTH +: WIDTH] != sel_data[c*WIDTH +: WIDTH]);
        end
        full_match = ~|ch_mis;
    end

    // Next-state and next-output logic; start overrides any state
    always_comb begin
        state_n  = state_q;
        trial_n  = trial_q;
        run_n    = run_q;
        loss_n   = loss_q;
        skew_n   = skew_q;
        sym_n    = sym_q;
        err_n    = err_q;
        mask_n   = mask_q;
        loss_inc = loss_q + 1'b1;

        if (start) begin
            state_n = S_SEARCH;
            trial_n = '0;
            run_n   = '0;
            loss_n  = '0;
            sym_n   = '0;
            err_n   = '0;
            mask_n  = '0;
        end else if (sym_clk_en) begin
            case (state_q)
                S_SEARCH: begin
                    if (full_match) begin
                        if (run_q == RUN_W'(LOCK_COUNT - 1)) begin
                            state_n = S_LOCKED;
                            skew_n  = trial_q;
                            loss_n  = '0;
                            run_n   = '0;
                        end else begin
                            run_n = run_q + 1'b1;
                        end
                    end else begin
                        run_n = '0;
                        if (trial_q == SKEW_W'(MAX_SKEW - 1)) begin
                            state_n = S_FAIL;
                        end else begin
                            trial_n = trial_q + 1'b1;
                        end
                    end
                end
                S_LOCKED: begin
                    if (sym_q != '1) begin
                        sym_n = sym_q + 1'b1;
                    end
                    if (full_match) begin
                        loss_n = '0;
                    end else begin
                        if (err_q != '1) begin
                            err_n = err_q + 1'b1;
                        end
                        mask_n = mask_q | ch_mis;
                        if (loss_inc == LOSS_W'(LOSS_COUNT)) begin
                            state_n = S_SEARCH;
                            trial_n = '0;
                            run_n   = '0;
                            loss_n  = '0;
                        end else begin
                            loss_n = loss_inc;
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        locked_n = (state_n == S_LOCKED);
        fail_n   = (state_n == S_FAIL);
    end

    // Register state, search bookkeeping and all outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            trial_q  <= '0;
            run_q    <= '0;
            loss_q   <= '0;
            skew_q   <= '0;
            sym_q    <= '0;
            err_q    <= '0;
            mask_q   <= '0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            trial_q  <= trial_n;
            run_q    <= run_n;
            loss_q   <= loss_n;
            skew_q   <= skew_n;
            sym_q    <= sym_n;
            err_q    <= err_n;
            mask_q   <= mask_n;
            locked_q <= locked_n;
            fail_q   <= fail_n;
        end
    end

    assign state       = state_q;
    assign locked      = locked_q;
    assign fail        = fail_q;
    assign skew_found  = skew_q;
    assign sym_count   = sym_q;
    assign err_count   = err_q;
    assign ch_err_mask = mask_q;

endmodule

// File: tb/tb_symbol_stream_xcheck.sv
// Bench for symbol_stream_xcheck. Stimulus pushes expected state transitions
// and expected output snapshots into queues; a monitor on the falling edge
// pops and compares them. Counter width is narrowed to 8 bits so that
// saturation is reached in a few hundred symbols.

module tb_symbol_stream_xcheck;

    localparam int WIDTH      = 18;
    localparam int NUM_CH     = 2;
    localparam int MAX_SKEW   = 8;
    localparam int SKEW_W     = 3;
    localparam int LOCK_COUNT = 16;
    localparam int LOSS_COUNT = 4;
    localparam int CNT_W      = 8;
    localparam int DW         = NUM_CH * WIDTH;

    logic                clk = 1'b0;
    logic                reset;
    logic                sym_clk_en;
    logic                start;
    logic [DW-1:0]       ref_data;
    logic [DW-1:0]       dut_data;
    logic [1:0]          state;
    logic                locked;
    logic                fail;
    logic [SKEW_W-1:0]   skew_found;
    logic [CNT_W-1:0]    sym_count;
    logic [CNT_W-1:0]    err_count;
    logic [NUM_CH-1:0]   ch_err_mask;

    symbol_stream_xcheck #(
        .WIDTH(WIDTH), .NUM_CH(NUM_CH), .MAX_SKEW(MAX_SKEW), .SKEW_W(SKEW_W),
        .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .sym_clk_en(sym_clk_en), .start(start),
        .ref_data(ref_data), .dut_data(dut_data), .state(state),
        .locked(locked), .fail(fail), .skew_found(skew_found),
        .sym_count(sym_count), .err_count(err_count), .ch_err_mask(ch_err_mask)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]        st;
        logic [SKEW_W-1:0] skew;
        logic [CNT_W-1:0]  sc;
        logic [CNT_W-1:0]  ec;
        logic [NUM_CH-1:0] mask;
    } exp_t;

    typedef struct packed {
        logic [1:0]        st;
        logic [SKEW_W-1:0] skew;
    } tr_t;

    exp_t  pr_q[$];
    string pr_name_q[$];
    tr_t   tr_q[$];
    string tr_name_q[$];

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    logic [7:0]    lfsr = 8'h01;
    logic [DW-1:0] hist [8];

    function automatic logic [DW-1:0] map_sym(input logic [7:0] s);
        logic [17:0] i_v;
        logic [17:0] q_v;
        i_v = {7'd0, s, 3'b001};
        q_v = {2'b11, ~s, 8'hA5};
        return {q_v, i_v};
    endfunction

    // mode 0: dut = delayed ref; 1: ch1 corrupted to 1; 2: dut all zero
    task automatic sym(input bit st, input int lag, input int mode);
        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
        hist[0]  = map_sym(lfsr);
        ref_data = hist[0];
        dut_data = hist[lag];
        if (mode == 1) dut_data[DW-1:WIDTH] = 18'h00001;
        if (mode == 2) dut_data = '0;
        start      = st;
        sym_clk_en = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        sym_clk_en = 1'b0;
    endtask

    task automatic syms(input int n, input int lag, input int mode);
        for (int i = 0; i < n; i++) sym(1'b0, lag, mode);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic probe(input string name, input logic [1:0] st, input int skew,
                         input int sc, input int ec, input logic [1:0] mask);
        exp_t e;
        e.st   = st;
        e.skew = SKEW_W'(skew);
        e.sc   = CNT_W'(sc);
        e.ec   = CNT_W'(ec);
        e.mask = mask;
        pr_q.push_back(e);
        pr_name_q.push_back(name);
    endtask

    task automatic expect_tr(input string name, input logic [1:0] st, input int skew);
        tr_t t;
        t.st   = st;
        t.skew = SKEW_W'(skew);
        tr_q.push_back(t);
        tr_name_q.push_back(name);
    endtask

    // Monitor: checks every state change and every queued snapshot
    initial begin
        logic [1:0] prev_state;
        exp_t       p;
        tr_t        t;
        string      nm;
        prev_state = 2'd0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_state = state;
            end else begin
                if (state !== prev_state) begin
                    tests++;
                    if (tr_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_transition: got state=%0d, want no change from %0d",
                                 state, prev_state);
                    end else begin
                        t  = tr_q.pop_front();
                        nm = tr_name_q.pop_front();
                        if (state !== t.st || skew_found !== t.skew ||
                            locked !== (t.st == 2'd2) || fail !== (t.st == 2'd3)) begin
                            fails++;
                            $display("FAIL %s: got st=%0d skew=%0d lk=%b fl=%b, want st=%0d skew=%0d",
                                     nm, state, skew_found, locked, fail, t.st, t.skew);
                        end
                    end
                    prev_state = state;
                end
                if (pr_q.size() > 0) begin
                    p  = pr_q.pop_front();
                    nm = pr_name_q.pop_front();
                    tests++;
                    if (state !== p.st || skew_found !== p.skew || sym_count !== p.sc ||
                        err_count !== p.ec || ch_err_mask !== p.mask ||
                        locked !== (p.st == 2'd2) || fail !== (p.st == 2'd3)) begin
                        fails++;
                        $display("FAIL %s: got st=%0d skew=%0d sym=%0d err=%0d mask=%b lk=%b fl=%b, want st=%0d skew=%0d sym=%0d err=%0d mask=%b",
                                 nm, state, skew_found, sym_count, err_count, ch_err_mask,
                                 locked, fail, p.st, p.skew, p.sc, p.ec, p.mask);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 8; k++) hist[k] = '0;
        reset      = 1'b1;
        sym_clk_en = 1'b0;
        start      = 1'b0;
        ref_data   = '0;
        dut_data   = '0;
        idle(3);
        reset  = 1'b0;
        mon_en = 1'b1;
        probe("reset", 2'd0, 0, 0, 0, 2'b00);

        // identical streams: lock on the 16th compare at skew 0
        syms(4, 0, 0);
        probe("idle_ignores_data", 2'd0, 0, 0, 0, 2'b00);
        expect_tr("start_search", 2'd1, 0);
        pulse_start();
        syms(15, 0, 0);
        probe("search_after_15", 2'd1, 0, 0, 0, 2'b00);
        expect_tr("lock_skew0", 2'd2, 0);
        syms(1, 0, 0);
        syms(4, 0, 0);
        probe("locked_after_20", 2'd2, 0, 4, 0, 2'b00);

        // dut lags by 3: trials 0..2 fail once each, then 16 matches
        expect_tr("restart_search", 2'd1, 0);
        pulse_start();
        probe("restart_clears", 2'd1, 0, 0, 0, 2'b00);
        syms(18, 3, 0);
        probe("skew3_after_18", 2'd1, 0, 0, 0, 2'b00);
        expect_tr("lock_skew3", 2'd2, 3);
        syms(1, 3, 0);
        syms(100, 3, 0);
        probe("skew3_100_syms", 2'd2, 3, 100, 0, 2'b00);

        // single error, loss reset, then four errors drop lock, then relock
        syms(1, 3, 1);
        probe("one_error", 2'd2, 3, 101, 1, 2'b10);
        syms(1, 3, 0);
        probe("loss_cleared", 2'd2, 3, 102, 1, 2'b10);
        syms(3, 3, 1);
        probe("three_errors_still_locked", 2'd2, 3, 105, 4, 2'b10);
        expect_tr("loss_of_lock", 2'd1, 3);
        syms(1, 3, 1);
        probe("lost_keeps_counters", 2'd1, 3, 106, 5, 2'b10);
        syms(18, 3, 0);
        probe("relock_pending", 2'd1, 3, 106, 5, 2'b10);
        expect_tr("relock_skew3", 2'd2, 3);
        syms(1, 3, 0);
        probe("relocked", 2'd2, 3, 106, 5, 2'b10);

        // start together with an enable while locked; then enable held low
        expect_tr("start_while_locked", 2'd1, 3);
        sym(1'b1, 3, 0);
        probe("start_clears_no_count", 2'd1, 3, 0, 0, 2'b00);
        idle(10);
        probe("enable_low_holds", 2'd1, 3, 0, 0, 2'b00);
        syms(18, 3, 0);
        probe("post_start_search_18", 2'd1, 3, 0, 0, 2'b00);
        expect_tr("relock_after_start", 2'd2, 3);
        syms(1, 3, 0);
        syms(5, 3, 0);
        probe("count_after_relock", 2'd2, 3, 5, 0, 2'b00);

        // dut stuck at zero: every trial fails, FAIL after 8 enables
        expect_tr("fail_search", 2'd1, 3);
        pulse_start();
        syms(7, 3, 2);
        probe("search_after_7_bad", 2'd1, 3, 0, 0, 2'b00);
        expect_tr("enter_fail", 2'd3, 3);
        syms(1, 3, 2);
        probe("fail_state", 2'd3, 3, 0, 0, 2'b00);
        syms(25, 0, 0);
        idle(25);
        probe("fail_holds_50", 2'd3, 3, 0, 0, 2'b00);

        // symbol counter saturation
        expect_tr("sat_search", 2'd1, 3);
        pulse_start();
        expect_tr("sat_lock", 2'd2, 3);
        syms(19, 3, 0);
        syms(254, 3, 0);
        probe("sym_254", 2'd2, 3, 254, 0, 2'b00);
        syms(1, 3, 0);
        probe("sym_255", 2'd2, 3, 255, 0, 2'b00);
        syms(5, 3, 0);
        probe("sym_saturated", 2'd2, 3, 255, 0, 2'b00);

        // reset in the middle of a search
        expect_tr("search_before_reset", 2'd1, 3);
        pulse_start();
        syms(2, 3, 0);
        probe("mid_search", 2'd1, 3, 0, 0, 2'b00);
        expect_tr("reset_to_idle", 2'd0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        probe("after_mid_reset", 2'd0, 0, 0, 0, 2'b00);

        idle(3);
        tests++;
        if (tr_q.size() != 0) begin
            fails++;
            $display("FAIL pending_transitions: got %0d unseen, want 0", tr_q.size());
        end
        tests++;
        if (pr_q.size() != 0) begin
            fails++;
            $display("FAIL pending_snapshots: got %0d unchecked, want 0", pr_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/symbol_stream_xcheck.md
Name: symbol_stream_xcheck

Overview:
Parametrised multi-channel cross-checker that compares a DUT symbol stream against a reference symbol stream, for example a new mapper against the 16-QAM reference mapper on I/Q. It searches automatically for the integer symbol skew between the two paths, declares lock, then counts symbols and mismatches per channel. It detects loss of lock and re-searches. It sits on sys_clk alongside the mapper/upsampler chain and feeds LEDs and SignalTap for on-board sanity runs.

Parameters:
WIDTH, 18, bits per channel sample (signed, compared bit-exact)
NUM_CH, 2, number of channels (ch0 = bits [WIDTH-1:0], I; ch1 = Q)
MAX_SKEW, 8, number of skew trials 0..MAX_SKEW-1 (max DUT lag in symbols)
SKEW_W, 3, width of skew fields; MAX_SKEW <= 2**SKEW_W
LOCK_COUNT, 16, consecutive full matches required to lock
LOSS_COUNT, 4, consecutive mismatching symbols in LOCKED that drop lock
CNT_W, 16, width of symbol and error counters

Ports:
clk  input  1  system clock (sys_clk)
reset  input  1  synchronous, active-high reset
sym_clk_en  input  1  symbol-rate enable; all comparisons and shifts occur only on cycles with sym_clk_en=1
start  input  1  one-cycle pulse; (re)starts search and clears counters
ref_data  input  NUM_CH*WIDTH  reference stream, valid on sym_clk_en
dut_data  input  NUM_CH*WIDTH  DUT stream, valid on sym_clk_en
state  output  2  0=IDLE, 1=SEARCH, 2=LOCKED, 3=FAIL
locked  output  1  state==LOCKED (registered)
fail  output  1  state==FAIL (registered)
skew_found  output  SKEW_W  skew at which lock was last acquired
sym_count  output  CNT_W  symbols compared while LOCKED, saturating
err_count  output  CNT_W  mismatching symbols while LOCKED, saturating
ch_err_mask  output  NUM_CH  sticky per-channel mismatch flags while LOCKED

Behaviour:
- Reset: state=IDLE, all outputs 0, delay line 0, trial=0, run=0, loss=0.
- Delay line: MAX_SKEW-1 registers of NUM_CH*WIDTH. It shifts on every sym_clk_en in all states, independent of start. tap[0]=ref_data (combinational); tap[k]=ref_data from k enabled cycles earlier.
- A match at skew d: dut_data == tap[d] on all channels. The per-channel compare uses a bit-exact equality.
- All state and outputs are registered. Their effect is visible on the cycle after the enabled edge.
- start takes priority over everything except reset, in any state: state<=SEARCH, trial<=0, run<=0, loss<=0, counters and mask <=0, skew_found unchanged. No comparison is made on that cycle even if sym_clk_en=1. The delay line still shifts.
- IDLE: wait for start; ignore data.
- SEARCH, on each sym_clk_en:
  - On a match at trial: run++. If run==LOCK_COUNT-1, go to LOCKED, set skew_found<=trial and loss<=0.
  - On a mismatch: run<=0. If trial==MAX_SKEW-1, go to FAIL; else trial++.
  - The first compare of a new trial is on the next enable.
- LOCKED, on each sym_clk_en at d=skew_found:
  - sym_count++ (saturates at all-ones).
  - On any channel mismatch: err_count++ (saturating), ch_err_mask |= per-channel mismatch, loss++.
  - If loss reaches LOSS_COUNT: go to SEARCH with trial=0, run=0. Counters and mask are kept.
  - On a full match: loss<=0.
- FAIL: hold all outputs until start or reset.
- Without sym_clk_en, no counter, trial or state changes occur, except through start or reset.
- Mid-operation reset returns to IDLE and clears everything on the next cycle.

Test Plan:
- Identical LFSR-mapped streams on ref/dut, start, then 20 symbols -> locked rises after the 16th enabled compare; skew_found=0; err_count=0.
- dut = ref delayed 3 symbols -> trials 0,1,2 each fail on their first mismatch, lock at skew_found=3; sym_count=100 after 100 further symbols; err_count=0.
- After lock at skew 3, corrupt ch1 of one symbol to 18'h00001 -> err_count=1, ch_err_mask=2'b10, still LOCKED; then 4 consecutive corrupt symbols -> SEARCH, then relock at 3 with err_count=5 retained.
- dut constant 0 against a non-zero ref -> all 8 trials fail -> state=FAIL after 8 enabled cycles; outputs hold for 50 cycles.
- Assert start on the same cycle as sym_clk_en while LOCKED -> SEARCH, counters 0, no compare counted that cycle; sym_clk_en held low for 10 cycles -> no state change.
- Force sym_count near 16'hFFFF in LOCKED -> saturates at 16'hFFFF; reset mid-SEARCH -> IDLE and all outputs 0 the next cycle.
